// File: rtl/pwm_reg_pkg.sv
// -----------------------------------------------------------------------------
// pwm_reg_pkg
// Shared constants and types for the multi-channel PWM register bank.
//   - per-channel byte offsets (address = channel*8 + offset)
//   - global register addresses (used only when PWM_REG_GLOBAL_SYNC_EN is set)
//   - ctrl / command bit positions
//   - pwm_chan_cfg_t: one channel's full register set. Count fields are held
//     at the maximum width and the channel uses the low CNT_W bits.
// -----------------------------------------------------------------------------
package pwm_reg_pkg;

  localparam logic [2:0] OFS_PERIOD_LO = 3'd0;
  localparam logic [2:0] OFS_PERIOD_HI = 3'd1;
  localparam logic [2:0] OFS_PHASE_LO  = 3'd2;
  localparam logic [2:0] OFS_PHASE_HI  = 3'd3;
  localparam logic [2:0] OFS_DUTY_LO   = 3'd4;
  localparam logic [2:0] OFS_DUTY_HI   = 3'd5;
  localparam logic [2:0] OFS_CTRL      = 3'd6;
  localparam logic [2:0] OFS_CMD       = 3'd7;

  localparam logic [7:0] ADDR_SYNC_CMD     = 8'hF0;
  localparam logic [7:0] ADDR_SYNC_MASK_LO = 8'hF1;
  localparam logic [7:0] ADDR_SYNC_MASK_HI = 8'hF2;
  localparam logic [7:0] ADDR_PENDING_LO   = 8'hF3;
  localparam logic [7:0] ADDR_PENDING_HI   = 8'hF4;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_INV_BIT  = 1;
  localparam int CTRL_INIT_BIT = 2;
  localparam int CTRL_TRIG_LSB = 5;
  localparam int CTRL_TRIG_MSB = 7;

  localparam int CMD_UPD_BIT = 0;
  localparam int CMD_SS_BIT  = 1;

  localparam int MAX_CNT_W = 16;
  localparam int TRIG_W    = 3;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] period;
    logic [MAX_CNT_W-1:0] phase;
    logic [MAX_CNT_W-1:0] duty_cycle;
    logic [TRIG_W-1:0]    trig_count;
    logic                 enable;
    logic                 invert;
    logic                 initial_val;
  } pwm_chan_cfg_t;

  // Byte image of the ctrl register; bits 4:3 are unimplemented.
  function automatic logic [7:0] ctrl_byte(input pwm_chan_cfg_t cfg);
    return {cfg.trig_count, 2'b00, cfg.initial_val, cfg.invert, cfg.enable};
  endfunction

endpackage

// File: rtl/pwm_reg_chan.sv
// -----------------------------------------------------------------------------
// pwm_reg_chan
// One PWM channel: 8 shadow bytes, update / soft-start requests, the active
// register set and the byte readback for this channel's address window.
// With PWM_REG_GLOBAL_SYNC_EN defined the channel also accepts a global
// sync-set input and reports its pending status.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_wr              committed write to this channel (strobe fall + decode)
//   i_ofs             byte offset within the channel (also used for reads)
//   i_wdata           write data
//   i_update          period-boundary pulse from this channel's counter
//   i_sync_set        global sync request (macro builds only)
//   o_pending         upd_req | ss_req (macro builds only)
//   o_rdata           readback byte for i_ofs
//   o_period/o_phase/o_duty_cycle/o_trig_count/o_invert/o_initial_val
//                     active values
//   o_enable          ss_req | active enable
// -----------------------------------------------------------------------------
module pwm_reg_chan
  import pwm_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PWM_REG_GLOBAL_SYNC_EN
  input  logic             i_sync_set,
  output logic             o_pending,
`endif
  input  logic             i_wr,
  input  logic [2:0]       i_ofs,
  input  logic [7:0]       i_wdata,
  input  logic             i_update,
  output logic [7:0]       o_rdata,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_phase,
  output logic [CNT_W-1:0] o_duty_cycle,
  output logic [2:0]       o_trig_count,
  output logic             o_enable,
  output logic             o_invert,
  output logic             o_initial_val
);

  // Hi bytes keep only CNT_W-8 bits so unimplemented bits always read 0.
  localparam logic [7:0] HI_MASK = 8'((16'd1 << (CNT_W - 8)) - 16'd1);

  pwm_chan_cfg_t r_shadow;
  pwm_chan_cfg_t r_active;
  logic          r_upd_req;
  logic          r_ss_req;

  logic w_cmd_wr;
  logic w_set_upd;
  logic w_set_ss;
  logic w_load;

  assign w_cmd_wr = i_wr && (i_ofs == OFS_CMD);
`ifdef PWM_REG_GLOBAL_SYNC_EN
  assign w_set_upd = (w_cmd_wr && i_wdata[CMD_UPD_BIT]) || i_sync_set;
  assign o_pending = r_upd_req | r_ss_req;
`else
  assign w_set_upd = w_cmd_wr && i_wdata[CMD_UPD_BIT];
`endif
  assign w_set_ss  = w_cmd_wr && i_wdata[CMD_SS_BIT];

  // Decision is made on the pre-edge request state; a disabled channel loads
  // as soon as upd_req is seen, without waiting for a boundary.
  assign w_load = (i_update && (r_upd_req || r_ss_req)) ||
                  (!r_active.enable && r_upd_req);

  // NOTE: every register, shadow bytes included, is reset: the shadow set is
  // copied to the outputs by the first load and must never carry X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_wr) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, which is what makes same-cycle write/load ordering defined.
      unique case (i_ofs)
        OFS_PERIOD_LO: r_shadow.period[7:0]      <= i_wdata;
        OFS_PERIOD_HI: r_shadow.period[15:8]     <= i_wdata & HI_MASK;
        OFS_PHASE_LO:  r_shadow.phase[7:0]       <= i_wdata;
        OFS_PHASE_HI:  r_shadow.phase[15:8]      <= i_wdata & HI_MASK;
        OFS_DUTY_LO:   r_shadow.duty_cycle[7:0]  <= i_wdata;
        OFS_DUTY_HI:   r_shadow.duty_cycle[15:8] <= i_wdata & HI_MASK;
        OFS_CTRL: begin
          r_shadow.enable      <= i_wdata[CTRL_EN_BIT];
          r_shadow.invert      <= i_wdata[CTRL_INV_BIT];
          r_shadow.initial_val <= i_wdata[CTRL_INIT_BIT];
          r_shadow.trig_count  <= i_wdata[CTRL_TRIG_MSB:CTRL_TRIG_LSB];
        end
        default: ;  // command register lives in the request flops
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_req <= 1'b0;
      r_ss_req  <= 1'b0;
      r_active  <= '0;
    end else begin
      r_upd_req <= w_set_upd || (r_upd_req && !(i_update || !r_active.enable));
      r_ss_req  <= w_set_ss  || (r_ss_req  && !i_update);
      if (w_load) r_active <= r_shadow;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns o_rdata and no latch forms.
    o_rdata = 8'h00;
    unique case (i_ofs)
      OFS_PERIOD_LO: o_rdata = r_shadow.period[7:0];
      OFS_PERIOD_HI: o_rdata = r_shadow.period[15:8];
      OFS_PHASE_LO:  o_rdata = r_shadow.phase[7:0];
      OFS_PHASE_HI:  o_rdata = r_shadow.phase[15:8];
      OFS_DUTY_LO:   o_rdata = r_shadow.duty_cycle[7:0];
      OFS_DUTY_HI:   o_rdata = r_shadow.duty_cycle[15:8];
      OFS_CTRL:      o_rdata = ctrl_byte(r_shadow);
      OFS_CMD:       o_rdata = {6'b0, r_ss_req, r_upd_req};
      default:       o_rdata = 8'h00;
    endcase
  end

  assign o_period      = r_active.period[CNT_W-1:0];
  assign o_phase       = r_active.phase[CNT_W-1:0];
  assign o_duty_cycle  = r_active.duty_cycle[CNT_W-1:0];
  assign o_trig_count  = r_active.trig_count;
  assign o_invert      = r_active.invert;
  assign o_initial_val = r_active.initial_val;
  assign o_enable      = r_ss_req | r_active.enable;

endmodule

// File: rtl/pwm_reg_bank.sv
// -----------------------------------------------------------------------------
// pwm_reg_bank
// Byte-addressed shadow/active register bank for NUM_CH PWM channels.
// Channel c owns addresses c*8..c*8+7. Writes commit on the falling edge of
// the synchronised write strobe. Optional global sync-update and pending
// status registers at 0xF0-0xF4 are built when PWM_REG_GLOBAL_SYNC_EN is
// defined; otherwise those addresses are unmapped.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   addr, wdata         byte address / write data
//   wr_en_wdata_sync    synchronised write strobe
//   update[NUM_CH]      per-channel period-boundary pulses
//   rdata               combinational read data for addr
//   period/phase/duty_cycle  NUM_CH*CNT_W active values, channel c at c*CNT_W
//   trig_count          NUM_CH*3 active trigger counts
//   enable/invert/initial_val/start  per-channel active control bits
// -----------------------------------------------------------------------------
module pwm_reg_bank
  import pwm_reg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              addr,
  input  logic [7:0]              wdata,
  input  logic                    wr_en_wdata_sync,
  input  logic [NUM_CH-1:0]       update,
  output logic [7:0]              rdata,
  output logic [NUM_CH*CNT_W-1:0] period,
  output logic [NUM_CH*CNT_W-1:0] phase,
  output logic [NUM_CH*CNT_W-1:0] duty_cycle,
  output logic [NUM_CH*3-1:0]     trig_count,
  output logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       invert,
  output logic [NUM_CH-1:0]       initial_val,
  output logic [NUM_CH-1:0]       start
);

  logic       r_hold;
  logic       w_wr_fedge;
  logic [7:0] w_chan_rdata [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold <= 1'b0;
    else        r_hold <= wr_en_wdata_sync;
  end

  assign w_wr_fedge = r_hold & ~wr_en_wdata_sync;

`ifdef PWM_REG_GLOBAL_SYNC_EN
  logic [NUM_CH-1:0] r_sync_mask;
  logic [NUM_CH-1:0] w_pending;
  logic              w_sync_cmd;
  logic [15:0]       w_mask16;
  logic [15:0]       w_pending16;

  assign w_sync_cmd  = w_wr_fedge && (addr == ADDR_SYNC_CMD) && wdata[0];
  assign w_mask16    = 16'(r_sync_mask);
  assign w_pending16 = 16'(w_pending);

  // Only NUM_CH mask bits exist; the rest read back as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_mask <= '0;
    end else if (w_wr_fedge) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr == ADDR_SYNC_MASK_LO && c < 8)  r_sync_mask[c] <= wdata[3'(c)];
        if (addr == ADDR_SYNC_MASK_HI && c >= 8) r_sync_mask[c] <= wdata[3'(c)];
      end
    end
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    logic w_chan_wr;
    assign w_chan_wr = w_wr_fedge && (addr[7:3] == 5'(c));

    pwm_reg_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef PWM_REG_GLOBAL_SYNC_EN
      .i_sync_set    (w_sync_cmd & r_sync_mask[c]),
      .o_pending     (w_pending[c]),
`endif
      .i_wr          (w_chan_wr),
      .i_ofs         (addr[2:0]),
      .i_wdata       (wdata),
      .i_update      (update[c]),
      .o_rdata       (w_chan_rdata[c]),
      .o_period      (period[c*CNT_W +: CNT_W]),
      .o_phase       (phase[c*CNT_W +: CNT_W]),
      .o_duty_cycle  (duty_cycle[c*CNT_W +: CNT_W]),
      .o_trig_count  (trig_count[c*3 +: 3]),
      .o_enable      (enable[c]),
      .o_invert      (invert[c]),
      .o_initial_val (initial_val[c])
    );
  end

  assign start = enable;

  // Channel windows end below 0x80, so they never overlap the global block.
  always_comb begin
    rdata = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr[7:3] == 5'(c)) rdata = w_chan_rdata[c];
    end
`ifdef PWM_REG_GLOBAL_SYNC_EN
    unique case (addr)
      ADDR_SYNC_MASK_LO: rdata = w_mask16[7:0];
      ADDR_SYNC_MASK_HI: rdata = w_mask16[15:8];
      ADDR_PENDING_LO:   rdata = w_pending16[7:0];
      ADDR_PENDING_HI:   rdata = w_pending16[15:8];
      default: ;
    endcase
`endif
  end

endmodule

// File: tb/tb_pwm_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_pwm_reg_bank
// Directed self-checking bench for pwm_reg_bank (NUM_CH=4, CNT_W=16).
// Builds with or without PWM_REG_GLOBAL_SYNC_EN; the global-sync section
// follows the macro.
// -----------------------------------------------------------------------------
module tb_pwm_reg_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic                    clk;
  logic                    rst_n;
  logic [7:0]              addr;
  logic [7:0]              wdata;
  logic                    wr_en_wdata_sync;
  logic [NUM_CH-1:0]       update;
  logic [7:0]              rdata;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH*CNT_W-1:0] phase;
  logic [NUM_CH*CNT_W-1:0] duty_cycle;
  logic [NUM_CH*3-1:0]     trig_count;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       invert;
  logic [NUM_CH-1:0]       initial_val;
  logic [NUM_CH-1:0]       start;

  int n_cmp = 0;
  int n_err = 0;

  pwm_reg_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .addr             (addr),
    .wdata            (wdata),
    .wr_en_wdata_sync (wr_en_wdata_sync),
    .update           (update),
    .rdata            (rdata),
    .period           (period),
    .phase            (phase),
    .duty_cycle       (duty_cycle),
    .trig_count       (trig_count),
    .enable           (enable),
    .invert           (invert),
    .initial_val      (initial_val),
    .start            (start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full strobe: high for one edge, low; returns just after the commit edge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; wr_en_wdata_sync = 1'b1;
    @(posedge clk); #1;
    wr_en_wdata_sync = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // update pulse one clk wide; returns just after the edge that sampled it.
  task automatic pulse(input logic [NUM_CH-1:0] m);
    @(posedge clk); #1;
    update = m;
    @(posedge clk); #1;
    update = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 8'h00; wdata = 8'h00; wr_en_wdata_sync = 1'b0; update = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst_period", period, 64'h0);
    check("rst_phase",  phase, 64'h0);
    check("rst_duty",   duty_cycle, 64'h0);
    check("rst_trig",   trig_count, 64'h0);
    check("rst_en",     enable, 64'h0);
    check("rst_start",  start, 64'h0);
    check("rst_inv",    invert, 64'h0);
    check("rst_init",   initial_val, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) chk_rd("rst_rd", 8'(i), 8'h00);

    // ---------------- ch1 disabled: loads two edges after strobe fall -----
    wr(8'h08, 8'h10);
    wr(8'h09, 8'h00);
    wr(8'h0E, 8'h01);
    wr(8'h0F, 8'h01);
    chk_rd("ch1_cmd_set", 8'h0F, 8'h01);
    check("ch1_period_pre", period[16 +: 16], 64'h0);
    @(posedge clk); #1;
    check("ch1_period", period[16 +: 16], 64'd16);
    check("ch1_en",     enable[1], 64'h1);
    check("ch1_start",  start[1], 64'h1);
    chk_rd("ch1_cmd_clr", 8'h0F, 8'h00);
    chk_rd("ch1_plo_rd",  8'h08, 8'h10);
    chk_rd("ch1_ctrl_rd", 8'h0E, 8'h01);

    // ---------------- ch0: enable, then boundary-gated duty change ----------
    wr(8'h04, 8'h10);
    wr(8'h06, 8'h01);
    wr(8'h07, 8'h01);
    @(posedge clk); #1;
    check("ch0_en",     enable[0], 64'h1);
    check("ch0_duty0",  duty_cycle[0 +: 16], 64'h0010);
    wr(8'h04, 8'h40);
    wr(8'h05, 8'h12);
    wr(8'h07, 8'h01);
    chk_rd("ch0_cmd_pend", 8'h07, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    check("ch0_duty_hold", duty_cycle[0 +: 16], 64'h0010);
    pulse(4'b0001);
    check("ch0_duty_new", duty_cycle[0 +: 16], 64'h1240);
    chk_rd("ch0_cmd_clr", 8'h07, 8'h00);
    chk_rd("ch0_dhi_rd",  8'h05, 8'h12);

    // ---------------- soft start on idle ch2 ----------------
    wr(8'h17, 8'h02);
    check("ss_en",    enable[2], 64'h1);
    check("ss_start", start[2], 64'h1);
    chk_rd("ss_cmd",  8'h17, 8'h02);
    pulse(4'b0100);
    check("ss_en_off",    enable[2], 64'h0);
    check("ss_start_off", start[2], 64'h0);
    chk_rd("ss_cmd_clr",  8'h17, 8'h00);

    // ---------------- ch3 ctrl fields ----------------
    wr(8'h1E, 8'hE6);
    wr(8'h1F, 8'h01);
    @(posedge clk); #1;
    check("ch3_trig", trig_count, 64'hE00);
    check("ch3_inv",  invert, 64'h8);
    check("ch3_init", initial_val, 64'h8);
    check("ch3_en",   enable, 64'h3);
    chk_rd("ch3_ctrl_rd", 8'h1E, 8'hE6);
    chk_rd("ch3_cmd_clr", 8'h1F, 8'h00);

`ifdef PWM_REG_GLOBAL_SYNC_EN
    // ---------------- global sync ----------------
    wr(8'h16, 8'h01);
    wr(8'h17, 8'h01);
    wr(8'h00, 8'h00);
    wr(8'h01, 8'h01);
    wr(8'h10, 8'h00);
    wr(8'h11, 8'h02);
    wr(8'h08, 8'h00);
    wr(8'h09, 8'h03);
    wr(8'hF1, 8'h05);
    wr(8'hF2, 8'h00);
    wr(8'hF0, 8'h01);
    chk_rd("gs_pend_lo", 8'hF3, 8'h05);
    chk_rd("gs_pend_hi", 8'hF4, 8'h00);
    chk_rd("gs_mask_lo", 8'hF1, 8'h05);
    chk_rd("gs_cmd_rd",  8'hF0, 8'h00);
    check("gs_en2",      enable[2], 64'h1);
    check("gs_hold",     period, 64'h0000_0000_0010_0000);
    pulse(4'b0111);
    check("gs_load",     period, 64'h0000_0200_0010_0100);
    chk_rd("gs_pend_clr", 8'hF3, 8'h00);
    wr(8'hF1, 8'hFF);
    chk_rd("gs_mask_trunc", 8'hF1, 8'h0F);
    chk_rd("gs_mask_hi",    8'hF2, 8'h00);
`else
    // ---------------- global block absent ----------------
    wr(8'hF1, 8'h05);
    wr(8'hF0, 8'h01);
    chk_rd("ng_pend",  8'hF3, 8'h00);
    chk_rd("ng_mask",  8'hF1, 8'h00);
    chk_rd("ng_ch0",   8'h07, 8'h00);
    chk_rd("ng_ch2",   8'h17, 8'h00);
`endif

    // ---------------- command write colliding with update[0] ----------------
    wr(8'h04, 8'h55);
    @(posedge clk); #1;
    addr = 8'h07; wdata = 8'h01; wr_en_wdata_sync = 1'b1;
    @(posedge clk); #1;
    wr_en_wdata_sync = 1'b0;
    update = 4'b0001;
    @(posedge clk); #1;
    update = '0;
    chk_rd("col_req", 8'h07, 8'h01);
    check("col_noload", duty_cycle[0 +: 16], 64'h1240);
    pulse(4'b0001);
    check("col_load", duty_cycle[0 +: 16], 64'h1255);
    chk_rd("col_clr", 8'h07, 8'h00);

    // ---------------- unmapped write ----------------
    wr(8'hE0, 8'hFF);
    chk_rd("um_rd",   8'hE0, 8'h00);
    chk_rd("um_dlo",  8'h04, 8'h55);
    chk_rd("um_ctrl", 8'h06, 8'h01);
    chk_rd("um_cmd",  8'h07, 8'h00);
    check("um_duty",  duty_cycle[0 +: 16], 64'h1255);
    check("um_per1",  period[16 +: 16], 64'd16);

    // ---------------- reset mid-operation ----------------
    wr(8'h07, 8'h01);
    chk_rd("mr_pend", 8'h07, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_duty", duty_cycle, 64'h0);
    check("mr_en",   enable, 64'h0);
    chk_rd("mr_cmd", 8'h07, 8'h00);
    chk_rd("mr_dlo", 8'h04, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mr_stay", duty_cycle, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
